// File: rtl/page_walk_arbiter_pkg.sv
// Shared types and constants for the two-port page-walk arbiter.
// Holds the FSM encoding, table-select values and the default walk timeout.
package page_walk_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Value of the latched SPEC bit selecting each page table.
  localparam logic TblSel8B  = 1'b0;
  localparam logic TblSel32B = 1'b1;

  localparam int unsigned TimeoutCycDefault = 15;

  // 32B pages cover four 8B pages, so the upper VPN bits index that table.
  function automatic logic [3:0] idx32(input logic [5:0] vpn);
    return vpn[5:2];
  endfunction

endpackage

// File: rtl/page_walk_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant.
// The pointer moves to the non-winning port only when the grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = ~gnt_o[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/page_walk_arbiter.sv
// Arbitrates page-table walks from two requesters onto the 8B and 32B page tables,
// one walk outstanding, with a per-walk timeout that reports ERR instead of DONE.
module page_walk_arbiter
  import page_walk_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RQ0_RQST,
  input  logic        RQ0_SPEC,
  input  logic [5:0]  RQ0_VPN,
  output logic        RQ0_DONE,
  output logic        RQ0_ERR,
  output logic [11:0] RQ0_DATA,
  input  logic        RQ1_RQST,
  input  logic        RQ1_SPEC,
  input  logic [5:0]  RQ1_VPN,
  output logic        RQ1_DONE,
  output logic        RQ1_ERR,
  output logic [11:0] RQ1_DATA,
  output logic        PAGE_8B_RQST,
  output logic [5:0]  PAGE_8B_LOOKUP,
  input  logic [11:0] PAGE_8B_RECV,
  input  logic        PAGE_8B_COMPLETE,
  output logic        PAGE_32B_RQST,
  output logic [3:0]  PAGE_32B_LOOKUP,
  input  logic [7:0]  PAGE_32B_RECV,
  input  logic        PAGE_32B_COMPLETE,
  output logic        BUSY
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        spec_q, spec_d;
  logic [5:0]  vpn_q, vpn_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] data0_q, data0_d;
  logic [11:0] data1_q, data1_d;

  logic        accept;
  logic [1:0]  gnt;
  logic [7:0]  cnt_inc;
  logic        sel_complete;
  logic [11:0] sel_recv;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({RQ1_RQST, RQ0_RQST}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign cnt_inc = cnt_q + 8'd1;

  // Only the table that was strobed is listened to; the other COMPLETE is ignored.
  assign sel_complete = (spec_q == TblSel32B) ? PAGE_32B_COMPLETE : PAGE_8B_COMPLETE;
  assign sel_recv     = (spec_q == TblSel32B) ? {4'b0000, PAGE_32B_RECV} : PAGE_8B_RECV;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    spec_d  = spec_q;
    vpn_d   = vpn_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    data0_d = data0_q;
    data1_d = data1_q;
    accept  = 1'b0;

    case (state_q)
      StIdle: begin
        if (RQ0_RQST || RQ1_RQST) begin
          accept  = 1'b1;
          port_d  = gnt[1];
          spec_d  = gnt[1] ? RQ1_SPEC : RQ0_SPEC;
          vpn_d   = gnt[1] ? RQ1_VPN : RQ0_VPN;
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (sel_complete) begin
          if (port_q) begin
            data1_d = sel_recv;
          end else begin
            data0_d = sel_recv;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutLimit) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      spec_q  <= 1'b0;
      vpn_q   <= 6'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      data0_q <= 12'd0;
      data1_q <= 12'd0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      spec_q  <= spec_d;
      vpn_q   <= vpn_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // Outputs decode purely from registered state so reset clears them at once.
  assign BUSY = (state_q != StIdle);

  assign PAGE_8B_RQST    = (state_q == StIssue) && (spec_q == TblSel8B);
  assign PAGE_32B_RQST   = (state_q == StIssue) && (spec_q == TblSel32B);
  assign PAGE_8B_LOOKUP  = (BUSY && (spec_q == TblSel8B)) ? vpn_q : 6'd0;
  assign PAGE_32B_LOOKUP = (BUSY && (spec_q == TblSel32B)) ? idx32(vpn_q) : 4'd0;

  assign RQ0_DONE = (state_q == StResp) && !port_q && !err_q;
  assign RQ1_DONE = (state_q == StResp) && port_q && !err_q;
  assign RQ0_ERR  = (state_q == StResp) && !port_q && err_q;
  assign RQ1_ERR  = (state_q == StResp) && port_q && err_q;

  assign RQ0_DATA = data0_q;
  assign RQ1_DATA = data1_q;

endmodule
